// File: rtl/fft_peak_pkg.sv
// Shared constants, the peak list entry type and the NFFT clamp helper
// used by the top-K FFT peak finder.
package fft_peak_pkg;

  localparam int DATA_W        = 16;
  localparam int MAX_LOG2N     = 10;
  localparam int POW_W         = 2 * DATA_W;
  localparam int MIN_NFFT_LOG2 = 3;
  localparam int PEAK_K        = 3;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] bin;
    logic [POW_W-1:0]     pow;
    logic                 valid;
  } peak_entry_t;

  typedef peak_entry_t [PEAK_K-1:0] peak_list_t;

  // Unsupported FFT sizes fall back to the largest one.
  function automatic logic [4:0] clamp_nfft(input logic [4:0] v);
    if (v < 5'(MIN_NFFT_LOG2) || v > 5'(MAX_LOG2N)) return 5'(MAX_LOG2N);
    return v;
  endfunction

endpackage

// File: rtl/fft_peak_topk_power.sv
// Two-stage |X|^2 = re*re + im*im with bin/last/flag passthrough so the
// side-band information stays aligned with the computed power.
module fft_power_calc #(
  parameter int DATA_W = 16,
  parameter int POW_W  = 32,
  parameter int BIN_W  = 10,
  parameter int FLAG_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  input  logic [BIN_W-1:0]  i_bin,
  input  logic              i_last,
  input  logic [FLAG_W-1:0] i_flags,
  output logic              o_valid,
  output logic [POW_W-1:0]  o_pow,
  output logic [BIN_W-1:0]  o_bin,
  output logic              o_last,
  output logic [FLAG_W-1:0] o_flags
);

  logic signed [2*DATA_W-1:0] w_re_ext;
  logic signed [2*DATA_W-1:0] w_im_ext;
  logic signed [2*DATA_W-1:0] r_re2;
  logic signed [2*DATA_W-1:0] r_im2;
  logic                       r_a_valid;
  logic [BIN_W-1:0]           r_a_bin;
  logic                       r_a_last;
  logic [FLAG_W-1:0]          r_a_flags;

  assign w_re_ext = {{DATA_W{i_re[DATA_W-1]}}, i_re};
  assign w_im_ext = {{DATA_W{i_im[DATA_W-1]}}, i_im};

  // Squares are non-negative and at most 2^30 each, so the sum fits unsigned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_valid <= 1'b0;
      r_re2     <= '0;
      r_im2     <= '0;
      r_a_bin   <= '0;
      r_a_last  <= 1'b0;
      r_a_flags <= '0;
      o_valid   <= 1'b0;
      o_pow     <= '0;
      o_bin     <= '0;
      o_last    <= 1'b0;
      o_flags   <= '0;
    end else begin
      r_a_valid <= i_valid;
      r_re2     <= w_re_ext * w_re_ext;
      r_im2     <= w_im_ext * w_im_ext;
      r_a_bin   <= i_bin;
      r_a_last  <= i_last;
      r_a_flags <= i_flags;
      o_valid   <= r_a_valid;
      o_pow     <= POW_W'($unsigned(r_re2)) + POW_W'($unsigned(r_im2));
      o_bin     <= r_a_bin;
      o_last    <= r_a_last;
      o_flags   <= r_a_flags;
    end
  end

endmodule

// File: rtl/fft_peak_topk.sv
// Top-K spectral peak finder: ranks positive-half FFT bins by power and
// publishes a sorted list per frame, with length checking and drop counting.
module fft_peak_topk #(
  parameter int DATA_W    = 16,
  parameter int MAX_LOG2N = 10,
  parameter int K         = 3,
  parameter int MIN_BIN   = 1,
  parameter int POW_W     = 2 * DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             curr_nfft,
  input  logic [POW_W-1:0]       pow_thresh,
  input  logic [2*DATA_W-1:0]    s_axis_data_tdata,
  input  logic                   s_axis_data_tvalid,
  input  logic                   s_axis_data_tlast,
  output logic                   s_axis_data_tready,
  output logic [K*MAX_LOG2N-1:0] peak_bin,
  output logic [K*POW_W-1:0]     peak_pow,
  output logic [K-1:0]           peak_valid,
  output logic [4:0]             result_nfft,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   frame_err,
  output logic [7:0]             drop_cnt
);

  import fft_peak_pkg::*;

  logic                 w_accept;
  logic [MAX_LOG2N-1:0] r_bin_cnt;
  logic [4:0]           r_nfft;
  logic [4:0]           r_done_nfft;
  logic [4:0]           w_nfft;
  logic [MAX_LOG2N-1:0] w_last_idx;
  logic [MAX_LOG2N-1:0] w_half_max;
  logic                 w_at_last;
  logic                 w_end;
  logic                 w_good;
  logic                 w_elig;

  logic                 r_s1_valid;
  logic [DATA_W-1:0]    r_s1_re;
  logic [DATA_W-1:0]    r_s1_im;
  logic [MAX_LOG2N-1:0] r_s1_bin;
  logic                 r_s1_last;
  logic [1:0]           r_s1_flags;

  logic                 w_p_valid;
  logic [POW_W-1:0]     w_p_pow;
  logic [MAX_LOG2N-1:0] w_p_bin;
  logic                 w_p_last;
  logic [1:0]           w_p_flags;

  logic                 r_s4_good;
  logic                 r_s4_err;

  peak_entry_t          r_list [K];
  peak_entry_t          w_base [K];
  peak_entry_t          w_next [K];
  peak_entry_t          w_entry;
  logic                 w_clear;
  logic                 w_ins;
  int                   w_pos;

  // The input stream is never back-pressured outside reset.
  assign s_axis_data_tready = ~rst;
  assign w_accept           = s_axis_data_tvalid & ~rst;

  // Bin 0 uses the live NFFT; later bins use the value latched at bin 0.
  assign w_nfft     = (r_bin_cnt == '0) ? clamp_nfft(curr_nfft) : r_nfft;
  assign w_last_idx = {MAX_LOG2N{1'b1}} >> (5'(MAX_LOG2N) - w_nfft);
  assign w_half_max = w_last_idx >> 1;
  assign w_at_last  = (r_bin_cnt == w_last_idx);
  assign w_end      = s_axis_data_tlast | w_at_last;
  assign w_good     = s_axis_data_tlast & w_at_last;
  assign w_elig     = (r_bin_cnt >= MAX_LOG2N'(MIN_BIN)) && (r_bin_cnt <= w_half_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_cnt   <= '0;
      r_nfft      <= '0;
      r_done_nfft <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_re     <= '0;
      r_s1_im     <= '0;
      r_s1_bin    <= '0;
      r_s1_last   <= 1'b0;
      r_s1_flags  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_re    <= s_axis_data_tdata[DATA_W-1:0];
        r_s1_im    <= s_axis_data_tdata[2*DATA_W-1:DATA_W];
        r_s1_bin   <= r_bin_cnt;
        r_s1_last  <= w_end;
        r_s1_flags <= {w_good, w_elig};
        if (r_bin_cnt == '0) r_nfft <= w_nfft;
        if (w_end) begin
          r_done_nfft <= w_nfft;
          r_bin_cnt   <= '0;
        end else begin
          r_bin_cnt <= r_bin_cnt + MAX_LOG2N'(1);
        end
      end
    end
  end

  fft_power_calc #(
    .DATA_W (DATA_W),
    .POW_W  (POW_W),
    .BIN_W  (MAX_LOG2N),
    .FLAG_W (2)
  ) u_power (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (r_s1_valid),
    .i_re    (r_s1_re),
    .i_im    (r_s1_im),
    .i_bin   (r_s1_bin),
    .i_last  (r_s1_last),
    .i_flags (r_s1_flags),
    .o_valid (w_p_valid),
    .o_pow   (w_p_pow),
    .o_bin   (w_p_bin),
    .o_last  (w_p_last),
    .o_flags (w_p_flags)
  );

  // A bin arriving while the previous frame commits starts from an empty list.
  assign w_clear = r_s4_good | r_s4_err;

  always_comb begin
    w_entry = '{bin: w_p_bin, pow: w_p_pow, valid: 1'b1};
    w_ins   = w_p_valid & w_p_flags[0] & (w_p_pow > pow_thresh);
    for (int i = 0; i < K; i++) begin
      w_base[i] = w_clear ? '0 : r_list[i];
    end
    // Strict '>' keeps earlier bins ahead on ties.
    w_pos = K;
    for (int i = K - 1; i >= 0; i--) begin
      if (!w_base[i].valid || (w_p_pow > w_base[i].pow)) w_pos = i;
    end
    for (int i = 0; i < K; i++) begin
      w_next[i] = w_base[i];
    end
    if (w_ins) begin
      for (int i = K - 1; i > 0; i--) begin
        if (i > w_pos)       w_next[i] = w_base[i-1];
        else if (i == w_pos) w_next[i] = w_entry;
      end
      if (w_pos == 0) w_next[0] = w_entry;
    end
  end

  // Result handshake: result_valid holds with stable data until an edge sees
  // result_valid && result_ready; a frame committing on that edge reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) r_list[i] <= '0;
      r_s4_good    <= 1'b0;
      r_s4_err     <= 1'b0;
      peak_bin     <= '0;
      peak_pow     <= '0;
      peak_valid   <= '0;
      result_nfft  <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      for (int i = 0; i < K; i++) r_list[i] <= w_next[i];
      r_s4_good <= w_p_valid & w_p_last & w_p_flags[1];
      r_s4_err  <= w_p_valid & w_p_last & ~w_p_flags[1];
      frame_err <= r_s4_err;
      if (r_s4_good) begin
        if (!result_valid || result_ready) begin
          for (int i = 0; i < K; i++) begin
            peak_bin[i*MAX_LOG2N +: MAX_LOG2N] <= r_list[i].bin;
            peak_pow[i*POW_W +: POW_W]         <= r_list[i].pow;
            peak_valid[i]                      <= r_list[i].valid;
          end
          result_nfft  <= r_done_nfft;
          result_valid <= 1'b1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_topk.sv
// Directed bench for fft_peak_topk: hand-computed peak lists, latency,
// length errors, back-pressure drops and mid-frame reset.
module tb_fft_peak_topk;

  localparam int DATA_W    = 16;
  localparam int MAX_LOG2N = 10;
  localparam int K         = 3;
  localparam int POW_W     = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [4:0]             curr_nfft;
  logic [POW_W-1:0]       pow_thresh;
  logic [2*DATA_W-1:0]    tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;
  logic [K*MAX_LOG2N-1:0] peak_bin;
  logic [K*POW_W-1:0]     peak_pow;
  logic [K-1:0]           peak_valid;
  logic [4:0]             result_nfft;
  logic                   result_valid;
  logic                   result_ready;
  logic                   frame_err;
  logic [7:0]             drop_cnt;

  fft_peak_topk #(
    .DATA_W(DATA_W), .MAX_LOG2N(MAX_LOG2N), .K(K), .MIN_BIN(1), .POW_W(POW_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .curr_nfft          (curr_nfft),
    .pow_thresh         (pow_thresh),
    .s_axis_data_tdata  (tdata),
    .s_axis_data_tvalid (tvalid),
    .s_axis_data_tlast  (tlast),
    .s_axis_data_tready (tready),
    .peak_bin           (peak_bin),
    .peak_pow           (peak_pow),
    .peak_valid         (peak_valid),
    .result_nfft        (result_nfft),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .frame_err          (frame_err),
    .drop_cnt           (drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver
  int t_bin[$];
  int t_re[$];
  int t_im[$];
  int sw_bin = -1;
  int sw_val = 0;

  task automatic clear_tones();
    t_bin.delete(); t_re.delete(); t_im.delete();
  endtask

  task automatic add_tone(input int b, input int re, input int im);
    t_bin.push_back(b); t_re.push_back(re); t_im.push_back(im);
  endtask

  function automatic logic [31:0] beat_data(input int b);
    logic [15:0] re;
    logic [15:0] im;
    re = '0;
    im = '0;
    foreach (t_bin[j]) begin
      if (t_bin[j] == b) begin
        re = 16'(t_re[j]);
        im = 16'(t_im[j]);
      end
    end
    return {im, re};
  endfunction

  task automatic send_frame(input int log2n, input int nbeats, input bit do_last, input bit gaps);
    curr_nfft = 5'(log2n);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 9) == 0) begin
        tvalid = 1'b0;
        @(posedge clk); #1;
      end
      if (b == sw_bin) curr_nfft = 5'(sw_val);
      tdata  = beat_data(b);
      tvalid = 1'b1;
      tlast  = do_last && (b == nbeats - 1);
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_out(output int c_rv, output int c_err);
    c_rv  = -1;
    c_err = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (result_valid && c_rv < 0) c_rv = c;
      if (frame_err && c_err < 0) c_err = c;
    end
  endtask

  task automatic accept_result(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check_val(tag, result_valid, 1'b0);
  endtask

  int crv;
  int cerr;

  initial begin
    rst = 1'b1; curr_nfft = 5'd10; pow_thresh = '0; tdata = '0;
    tvalid = 1'b0; tlast = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tready", tready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_tready_rel", tready, 1'b1);
    check_val("rst_rv", result_valid, 1'b0);
    check_val("rst_pvalid", peak_valid, 3'b000);
    check_val("rst_bin", peak_bin, '0);
    check_val("rst_drop", drop_cnt, 8'd0);

    // Single tone, 60^2+80^2 = 10000
    clear_tones(); add_tone(46, 60, 80);
    send_frame(10, 1024, 1, 1);
    wait_out(crv, cerr);
    check_val("t1_latency", crv, 4);
    check_val("t1_err", cerr, -1);
    check_val("t1_bin0", peak_bin[9:0], 10'd46);
    check_val("t1_pow0", peak_pow[31:0], 32'd10000);
    check_val("t1_pvalid", peak_valid, 3'b001);
    check_val("t1_nfft", result_nfft, 5'd10);
    accept_result("t1_accept");

    // Three tones plus a weaker fourth
    clear_tones();
    add_tone(20, 100, 0); add_tone(100, 300, 0); add_tone(300, 200, 0); add_tone(400, 50, 0);
    send_frame(10, 1024, 1, 1);
    wait_out(crv, cerr);
    check_val("t2_latency", crv, 4);
    check_val("t2_bins", peak_bin, {10'd20, 10'd300, 10'd100});
    check_val("t2_pows", peak_pow, {32'd10000, 32'd40000, 32'd90000});
    check_val("t2_pvalid", peak_valid, 3'b111);
    accept_result("t2_accept");

    // Ties (500 each) and DC exclusion
    clear_tones();
    add_tone(0, 20, 10); add_tone(50, 20, 10); add_tone(60, -20, 10);
    send_frame(10, 1024, 1, 1);
    wait_out(crv, cerr);
    check_val("t3_bins", peak_bin, {10'd0, 10'd60, 10'd50});
    check_val("t3_pows", peak_pow, {32'd0, 32'd500, 32'd500});
    check_val("t3_pvalid", peak_valid, 3'b011);
    accept_result("t3_accept");
    pow_thresh = 32'd500;
    send_frame(10, 1024, 1, 1);
    wait_out(crv, cerr);
    check_val("t3_thr_latency", crv, 4);
    check_val("t3_thr_pvalid", peak_valid, 3'b000);
    check_val("t3_thr_pows", peak_pow, '0);
    accept_result("t3_thr_accept");
    pow_thresh = '0;

    // Mirror half excluded; curr_nfft change mid-frame ignored
    clear_tones(); add_tone(200, 1000, 0); add_tone(10, 3, 0);
    sw_bin = 100; sw_val = 10;
    send_frame(8, 256, 1, 1);
    sw_bin = -1;
    wait_out(crv, cerr);
    check_val("t4_latency", crv, 4);
    check_val("t4_err", cerr, -1);
    check_val("t4_bin0", peak_bin[9:0], 10'd10);
    check_val("t4_pow0", peak_pow[31:0], 32'd9);
    check_val("t4_pvalid", peak_valid, 3'b001);
    check_val("t4_nfft", result_nfft, 5'd8);
    accept_result("t4_accept");

    // Short frame -> error, then a correct 512-bin frame
    clear_tones(); add_tone(7, 5, 0);
    send_frame(9, 301, 1, 0);
    wait_out(crv, cerr);
    check_val("t5_err_lat", cerr, 4);
    check_val("t5_no_rv", crv, -1);
    send_frame(9, 512, 1, 1);
    wait_out(crv, cerr);
    check_val("t5_latency", crv, 4);
    check_val("t5_err", cerr, -1);
    check_val("t5_bin0", peak_bin[9:0], 10'd7);
    check_val("t5_pow0", peak_pow[31:0], 32'd25);
    check_val("t5_nfft", result_nfft, 5'd9);
    accept_result("t5_accept");

    // Back-pressure: held result, drop, commit on the accepting edge
    clear_tones(); add_tone(2, 7, 0);
    send_frame(3, 8, 1, 0);
    wait_out(crv, cerr);
    check_val("t6_a_latency", crv, 4);
    clear_tones(); add_tone(3, 9, 0);
    send_frame(3, 8, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    check_val("t6_hold_rv", result_valid, 1'b1);
    check_val("t6_hold_bin", peak_bin[9:0], 10'd2);
    check_val("t6_hold_pow", peak_pow[31:0], 32'd49);
    check_val("t6_drop", drop_cnt, 8'd1);
    clear_tones(); add_tone(1, 11, 0);
    send_frame(3, 8, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_pre_bin", peak_bin[9:0], 10'd2);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check_val("t6_c_rv", result_valid, 1'b1);
    check_val("t6_c_bin", peak_bin[9:0], 10'd1);
    check_val("t6_c_pow", peak_pow[31:0], 32'd121);
    check_val("t6_c_drop", drop_cnt, 8'd1);
    accept_result("t6_accept");

    // Reset mid-frame with a result pending
    clear_tones(); add_tone(2, 7, 0);
    send_frame(3, 8, 1, 0);
    wait_out(crv, cerr);
    clear_tones(); add_tone(150, 200, 0);
    send_frame(10, 201, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("t7_tready", tready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("t7_rv", result_valid, 1'b0);
    check_val("t7_pvalid", peak_valid, 3'b000);
    check_val("t7_bin", peak_bin, '0);
    check_val("t7_pow", peak_pow, '0);
    check_val("t7_drop", drop_cnt, 8'd0);
    check_val("t7_nfft", result_nfft, 5'd0);
    clear_tones(); add_tone(33, 40, 0);
    send_frame(10, 1024, 1, 1);
    wait_out(crv, cerr);
    check_val("t7_latency", crv, 4);
    check_val("t7_err", cerr, -1);
    check_val("t7_bin0", peak_bin[9:0], 10'd33);
    check_val("t7_pow0", peak_pow[31:0], 32'd1600);
    check_val("t7_pvalid2", peak_valid, 3'b001);
    accept_result("t7_accept");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_peak_topk.md
Name: fft_peak_topk

Overview:
- Successor to the single-peak FFT max-bin finder.
- Consumes the FFT core's output stream, computes per-bin power over the positive-frequency half-spectrum, and keeps the K strongest bins in a rank-sorted list.
- Applies a power threshold and a low-bin exclusion, checks frame length against the active NFFT, and presents a per-frame result over a valid/ready handshake to the frequency/note/display path.

Parameters:
- DATA_W, 16, width of each signed real/imag component.
- MAX_LOG2N, 10, largest supported log2(NFFT); also the bin index width.
- K, 3, number of peaks tracked (1..8).
- MIN_BIN, 1, bins below this index are never ranked (DC exclusion).
- POW_W, 2*DATA_W, unsigned power width.

Ports:
- clk  in  1  system clock (FFT clock domain).
- rst  in  1  synchronous active-high reset.
- curr_nfft  in  5  log2 of the active FFT length.
- pow_thresh  in  POW_W  a bin is ranked only if its power > pow_thresh.
- s_axis_data_tdata  in  2*DATA_W  [DATA_W-1:0]=re, [2*DATA_W-1:DATA_W]=im, two's complement.
- s_axis_data_tvalid  in  1  input beat valid.
- s_axis_data_tlast  in  1  last bin of frame.
- s_axis_data_tready  out  1  constant 1 when not in reset; 0 during rst.
- peak_bin  out  K*MAX_LOG2N  slot i at [i*MAX_LOG2N +: MAX_LOG2N]; slot 0 = strongest.
- peak_pow  out  K*POW_W  power of slot i.
- peak_valid  out  K  slot i holds a real peak.
- result_nfft  out  5  NFFT used for this result.
- result_valid  out  1  result pending.
- result_ready  in  1  consumer accepts the result.
- frame_err  out  1  one-cycle pulse on a length mismatch.
- drop_cnt  out  8  saturating count of frames dropped while a result was pending.

Behaviour:
- Reset: every output is 0 and the working list is cleared. The bin counter returns to 0. A frame in progress is abandoned; the next accepted beat is bin 0.
- NFFT latch: curr_nfft is latched on the first beat of each frame (bin 0). Values outside 3..MAX_LOG2N are treated as MAX_LOG2N. N = 1<<latched value. Changes to curr_nfft mid-frame are ignored until the next frame.
- Pipeline, each stage advancing only on accepted beats plus a flush for last:
  - S1 registers re, im, bin and last.
  - S2 computes the unsigned power re*re + im*im. No overflow: the worst case is 2^31, which fits POW_W=32.
  - S3 inserts the bin into the working list.
- Eligibility: a bin is eligible if MIN_BIN <= bin < N/2 and power > pow_thresh. Ineligible bins still advance the counter.
- Insertion:
  - A bin ranks ahead of an existing entry only if its power is strictly greater, so ties keep the lower (earlier) bin in the higher slot.
  - Entries below the insertion point shift down one slot; slot K-1 is discarded.
  - Empty slots carry bin=0, pow=0, valid=0.
- Frame end, good: the last beat is accepted with tlast=1 and bin==N-1.
  - If result_valid=0, the working list is copied to the outputs and result_nfft is set.
  - result_valid rises 4 clk cycles after the edge that accepted the tlast beat.
  - The working list is cleared for the next frame.
- Handshake:
  - result_valid stays high and all outputs stay stable until result_valid && result_ready at an edge.
  - result_valid falls on that edge unless a new good frame commits on the same edge, in which case the new result loads and valid stays high.
- Drop: a good frame that ends while a result is still pending (and not being accepted that cycle) is discarded. drop_cnt increments, saturating at 255, and the working list is cleared.
- Error:
  - Either tlast=1 with bin != N-1, or bin==N-1 with tlast=0.
  - frame_err pulses at the same latency as result_valid would have.
  - No result is published, the list is cleared, and the bin counter resets so the next beat is bin 0.
- tvalid gaps are allowed anywhere; the pipeline holds.

Decomposition:
- Package fft_peak_pkg holds:
  - the constants MAX_LOG2N, DATA_W, POW_W, MIN_NFFT_LOG2=3;
  - the typedefs peak_entry_t {bin, pow, valid} and peak_list_t (array of K entries).
- Sub-module fft_power_calc holds the 2-stage square-and-add with valid/last/bin passthrough.
- The sorted-insert logic stays in the top module.

Test Plan:
- Single tone: nfft=10, bin 46 power 10000, all others 0, thresh=0 -> slot0 bin=46, peak_valid=001, result_valid 4 cycles after tlast.
- Three tones: bins 20, 100, 300 with re=100, 300, 200, im=0 -> slots 100/20000? No: slots 0..2 = bin 100 (90000), bin 300 (40000), bin 20 (10000); a fourth weaker bin 400 is absent.
- Tie and exclusion: bins 0, 50 and 60 all power 500 -> slot0=50, slot1=60, bin 0 not ranked. With thresh=500 -> peak_valid=000.
- Mirror half: nfft=8, strong bin 200 (>=128) -> not ranked; result_nfft=8.
- Length errors: nfft=9 frame with tlast at bin 300 -> frame_err pulse, no result_valid. A following correct 512-bin frame -> normal result.
- Backpressure: hold result_ready=0 across two frames -> first result held unchanged, drop_cnt=1. Assert ready on the same edge a third frame commits -> result_valid stays 1 with the new data.
- Reset mid-frame: reset at bin 200 -> all outputs 0; the next frame reports correctly from bin 0.
